// File: rtl/pa_f_sram_pkg.sv
// Shared definitions for the parametrised FPGA single-port SRAM model:
// FSM encoding, the default output-stage setting and an address-width helper.
package pa_f_sram_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  localparam int OUT_REG_DEFAULT = 0;

  // Smallest n such that 2**n >= value.
  function automatic int pa_f_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pa_f_sram_array.sv
// Behavioural DEPTH x DATA_WIDTH storage with per-bit write enable and a
// registered read port; no control logic so it maps onto FPGA block RAM.
module pa_f_sram_array #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 45,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_wmask,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Contents are deliberately not reset; the wrapper's init sweep clears them.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (i_wmask[i]) begin
          r_mem[i_addr][i] <= i_wdata[i];
        end
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pa_f_spsram_init_wrap.sv
// Single-port SRAM wrapper: hardware init sweep, valid/ready request port,
// masked writes, fixed-latency reads with optional output flop and data hold.
module pa_f_spsram_init_wrap
  import pa_f_sram_pkg::*;
#(
  parameter int                   DEPTH      = 64,
  parameter int                   DATA_WIDTH = 45,
  parameter int                   ADDR_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
  parameter int                   OUT_REG    = OUT_REG_DEFAULT
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_req,
  output logic                  init_busy,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  if (DEPTH < 2 || pa_f_clog2(DEPTH) > ADDR_WIDTH) begin : g_bad_cfg
    $error("pa_f_spsram_init_wrap: DEPTH must be >= 2 and fit in ADDR_WIDTH bits");
  end

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_init_addr;

  logic                  w_init_busy;
  logic                  w_req_rdy;
  logic                  w_accept;
  logic                  w_in_range;
  logic                  w_user_we;
  logic                  w_user_re;
  logic                  w_arr_we;
  logic                  w_arr_re;
  logic [ADDR_WIDTH-1:0] w_arr_addr;
  logic [DATA_WIDTH-1:0] w_arr_wdata;
  logic [DATA_WIDTH-1:0] w_arr_wmask;
  logic [DATA_WIDTH-1:0] w_arr_rdata;
  logic [DATA_WIDTH-1:0] w_rdata_p1;

  logic                  r_vld_p1;
  logic                  r_oor_p1;
  logic [DATA_WIDTH-1:0] r_hold;

  // init_req takes priority over a same-cycle request, so ready drops combinationally.
  assign w_init_busy = (r_state == ST_INIT);
  assign w_req_rdy   = (r_state == ST_IDLE) & ~init_req;
  assign w_accept    = req_vld & w_req_rdy;
  assign w_in_range  = ({1'b0, req_addr} < DEPTH_EXT);
  assign w_user_we   = w_accept & req_wr & w_in_range;
  assign w_user_re   = w_accept & ~req_wr;

  assign init_busy = w_init_busy;
  assign req_rdy   = w_req_rdy;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state     <= ST_INIT;
      r_init_addr <= '0;
    end else if (init_req) begin
      r_state     <= ST_INIT;
      r_init_addr <= '0;
    end else if (r_state == ST_INIT) begin
      if (r_init_addr == LAST_ADDR) begin
        r_state     <= ST_IDLE;
        r_init_addr <= '0;
      end else begin
        r_init_addr <= r_init_addr + 1'b1;
      end
    end
  end

  // The sweep owns the single port while busy; user accesses only exist in IDLE.
  assign w_arr_we    = w_init_busy | w_user_we;
  assign w_arr_re    = w_user_re & w_in_range;
  assign w_arr_addr  = w_init_busy ? r_init_addr : req_addr;
  assign w_arr_wdata = w_init_busy ? INIT_VAL    : req_wdata;
  assign w_arr_wmask = w_init_busy ? '1          : req_wmask;

  pa_f_sram_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .i_clk   (forever_cpuclk),
    .i_we    (w_arr_we),
    .i_re    (w_arr_re),
    .i_addr  (w_arr_addr),
    .i_wdata (w_arr_wdata),
    .i_wmask (w_arr_wmask),
    .o_rdata (w_arr_rdata)
  );

  // p1: array output valid; out-of-range reads are forced to zero here.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_vld_p1 <= 1'b0;
      r_oor_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_user_re;
      r_oor_p1 <= w_user_re & ~w_in_range;
    end
  end

  assign w_rdata_p1 = r_oor_p1 ? '0 : w_arr_rdata;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_hold <= '0;
    end else if (r_vld_p1) begin
      r_hold <= w_rdata_p1;
    end
  end

  // With OUT_REG the hold register doubles as the output flop (p2).
  if (OUT_REG == 0) begin : g_out_comb
    assign rd_vld  = r_vld_p1;
    assign rd_data = r_vld_p1 ? w_rdata_p1 : r_hold;
  end else begin : g_out_reg
    logic r_vld_p2;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
        r_vld_p2 <= 1'b0;
      end else begin
        r_vld_p2 <= r_vld_p1;
      end
    end

    assign rd_vld  = r_vld_p2;
    assign rd_data = r_hold;
  end

endmodule

// File: tb/tb_pa_f_spsram_init_wrap.sv
// Directed bench for pa_f_spsram_init_wrap: two 64-entry instances (OUT_REG 0/1)
// share one stimulus stream; a 48-entry instance covers out-of-range addresses.
module tb_pa_f_spsram_init_wrap;

  localparam logic [44:0] IV   = 45'h1555_5555_5555;
  localparam logic [44:0] ONES = {45{1'b1}};
  localparam logic [44:0] D1   = 45'h0AAA_AAAA_0001;
  localparam logic [44:0] D2   = 45'h1000_0000_0002;
  localparam logic [44:0] D3   = 45'h0F0F_0F0F_0F03;
  localparam logic [44:0] D10  = 45'h0123_4567_89AB;

  logic        clk = 1'b0;
  logic        cpurst_b = 1'b0;

  logic        a_init_req = 1'b0, a_req_vld = 1'b0, a_req_wr = 1'b0;
  logic [5:0]  a_req_addr = '0;
  logic [44:0] a_wdata = '0, a_wmask = '0;

  logic        b_init_req = 1'b0, b_req_vld = 1'b0, b_req_wr = 1'b0;
  logic [5:0]  b_req_addr = '0;
  logic [44:0] b_wdata = '0, b_wmask = '0;

  logic        busy0, rdy0, vld0, busy1, rdy1, vld1, busy2, rdy2, vld2;
  logic [44:0] data0, data1, data2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pa_f_spsram_init_wrap #(.DEPTH(64), .DATA_WIDTH(45), .ADDR_WIDTH(6), .INIT_VAL(IV), .OUT_REG(0)) dut0 (
    .forever_cpuclk(clk), .cpurst_b(cpurst_b), .init_req(a_init_req), .init_busy(busy0),
    .req_vld(a_req_vld), .req_rdy(rdy0), .req_wr(a_req_wr), .req_addr(a_req_addr),
    .req_wdata(a_wdata), .req_wmask(a_wmask), .rd_vld(vld0), .rd_data(data0));

  pa_f_spsram_init_wrap #(.DEPTH(64), .DATA_WIDTH(45), .ADDR_WIDTH(6), .INIT_VAL(IV), .OUT_REG(1)) dut1 (
    .forever_cpuclk(clk), .cpurst_b(cpurst_b), .init_req(a_init_req), .init_busy(busy1),
    .req_vld(a_req_vld), .req_rdy(rdy1), .req_wr(a_req_wr), .req_addr(a_req_addr),
    .req_wdata(a_wdata), .req_wmask(a_wmask), .rd_vld(vld1), .rd_data(data1));

  pa_f_spsram_init_wrap #(.DEPTH(48), .DATA_WIDTH(45), .ADDR_WIDTH(6), .INIT_VAL(IV), .OUT_REG(0)) dut2 (
    .forever_cpuclk(clk), .cpurst_b(cpurst_b), .init_req(b_init_req), .init_busy(busy2),
    .req_vld(b_req_vld), .req_rdy(rdy2), .req_wr(b_req_wr), .req_addr(b_req_addr),
    .req_wdata(b_wdata), .req_wmask(b_wmask), .rd_vld(vld2), .rd_data(data2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [5:0] addr, input logic [44:0] data, input logic [44:0] mask);
    a_req_vld  = 1'b1;
    a_req_wr   = 1'b1;
    a_req_addr = addr;
    a_wdata    = data;
    a_wmask    = mask;
    tick();
    a_req_vld  = 1'b0;
    a_req_wr   = 1'b0;
  endtask

  // Read on both 64-entry instances: OUT_REG=0 answers after one edge, OUT_REG=1 after two.
  task automatic a_read(input string tag, input logic [5:0] addr, input logic [44:0] exp);
    a_req_vld  = 1'b1;
    a_req_wr   = 1'b0;
    a_req_addr = addr;
    tick();
    a_req_vld  = 1'b0;
    chk({tag, "_vld0"}, vld0, 1'b1);
    chk({tag, "_data0"}, data0, exp);
    tick();
    chk({tag, "_vld0_end"}, vld0, 1'b0);
    chk({tag, "_vld1"}, vld1, 1'b1);
    chk({tag, "_data1"}, data1, exp);
  endtask

  task automatic b_read(input string tag, input logic [5:0] addr, input logic [44:0] exp);
    b_req_vld  = 1'b1;
    b_req_wr   = 1'b0;
    b_req_addr = addr;
    tick();
    b_req_vld  = 1'b0;
    chk({tag, "_vld2"}, vld2, 1'b1);
    chk({tag, "_data2"}, data2, exp);
  endtask

  initial begin
    int n0, n1, n2, n, vcount;

    // Reset state
    repeat (3) tick();
    chk("rst_busy0", busy0, 1'b1);
    chk("rst_rdy0", rdy0, 1'b0);
    chk("rst_vld0", vld0, 1'b0);
    chk("rst_data0", data0, 45'h0);
    chk("rst_vld1", vld1, 1'b0);
    chk("rst_data1", data1, 45'h0);
    chk("rst_busy2", busy2, 1'b1);

    // Sweep length after reset release
    cpurst_b = 1'b1;
    n0 = 0; n1 = 0; n2 = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (!busy0 && n0 == 0) n0 = k;
      if (!busy1 && n1 == 0) n1 = k;
      if (!busy2 && n2 == 0) n2 = k;
    end
    chk("sweep_len0", n0, 64);
    chk("sweep_len1", n1, 64);
    chk("sweep_len2", n2, 48);
    chk("rdy0_idle", rdy0, 1'b1);
    chk("rdy1_idle", rdy1, 1'b1);
    chk("rdy2_idle", rdy2, 1'b1);

    a_read("init_a0", 6'd0, IV);
    a_read("init_a31", 6'd31, IV);
    a_read("init_a63", 6'd63, IV);

    // Masked write, then an all-zero-mask no-op
    a_write(6'd5, ONES, 45'h0000_0000_00FF);
    a_read("mask_a5", 6'd5, 45'h1555_5555_55FF);
    a_write(6'd5, 45'h0, 45'h0);
    a_read("nomask_a5", 6'd5, 45'h1555_5555_55FF);

    // Write immediately followed by a read of the same address
    a_write(6'd10, D10, ONES);
    a_read("wr_rd_a10", 6'd10, D10);

    // Back-to-back reads
    a_write(6'd1, D1, ONES);
    a_write(6'd2, D2, ONES);
    a_write(6'd3, D3, ONES);
    a_req_vld = 1'b1; a_req_wr = 1'b0; a_req_addr = 6'd1;
    tick();
    chk("b2b_e1_vld0", vld0, 1'b1);
    chk("b2b_e1_data0", data0, D1);
    a_req_addr = 6'd2;
    tick();
    chk("b2b_e2_data0", data0, D2);
    chk("b2b_e2_vld1", vld1, 1'b1);
    chk("b2b_e2_data1", data1, D1);
    a_req_addr = 6'd3;
    tick();
    chk("b2b_e3_vld0", vld0, 1'b1);
    chk("b2b_e3_data0", data0, D3);
    chk("b2b_e3_data1", data1, D2);
    a_req_vld = 1'b0;
    tick();
    chk("b2b_e4_vld0", vld0, 1'b0);
    chk("b2b_e4_data0", data0, D3);
    chk("b2b_e4_vld1", vld1, 1'b1);
    chk("b2b_e4_data1", data1, D3);

    // Read-data hold over idle cycles
    vcount = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      vcount += int'(vld0) + int'(vld1);
    end
    chk("hold_vld_count", vcount, 0);
    chk("hold_data0", data0, D3);
    chk("hold_data1", data1, D3);

    // init_req collides with a write request
    a_init_req = 1'b1;
    a_req_vld  = 1'b1; a_req_wr = 1'b1; a_req_addr = 6'd7;
    a_wdata    = 45'h1; a_wmask = ONES;
    #1;
    chk("coll_rdy0_same", rdy0, 1'b0);
    tick();
    a_init_req = 1'b0; a_req_vld = 1'b0; a_req_wr = 1'b0;
    n = 0;
    while (!rdy0 && n < 200) begin
      tick();
      n++;
    end
    chk("coll_rdy_low_cycles", n, 64);
    chk("coll_hold_data0", data0, D3);
    chk("coll_hold_data1", data1, D3);
    a_read("coll_a7", 6'd7, IV);
    a_read("coll_a1", 6'd1, IV);

    // Out-of-range access on the 48-entry instance
    b_req_vld = 1'b1; b_req_wr = 1'b1; b_req_addr = 6'd50;
    b_wdata = ONES; b_wmask = ONES;
    tick();
    b_req_vld = 1'b0; b_req_wr = 1'b0;
    b_read("oor_a50", 6'd50, 45'h0);
    b_read("oor_a2", 6'd2, IV);
    b_read("oor_a47", 6'd47, IV);

    // Asynchronous reset, then reset again in the middle of the sweep
    cpurst_b = 1'b0;
    #1;
    chk("arst_busy0", busy0, 1'b1);
    chk("arst_rdy0", rdy0, 1'b0);
    chk("arst_data0", data0, 45'h0);
    chk("arst_data1", data1, 45'h0);
    chk("arst_data2", data2, 45'h0);
    tick();
    cpurst_b = 1'b1;
    repeat (20) tick();
    chk("mid_busy_before", busy0, 1'b1);
    cpurst_b = 1'b0;
    #1;
    chk("mid_busy0", busy0, 1'b1);
    chk("mid_rdy0", rdy0, 1'b0);
    chk("mid_vld0", vld0, 1'b0);
    tick();
    cpurst_b = 1'b1;
    n = 0;
    while (busy0 && n < 200) begin
      tick();
      n++;
    end
    chk("mid_sweep_len", n, 64);
    chk("mid_rdy_after", rdy0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
